// File: rtl/cpu_ctrl_pkg.sv
// Shared types and code points for the hardwired CPU sequencer: states,
// opcodes, datapath select/function encodings and the idle control vector.
package cpu_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_FETCH_L,
      ST_FETCH_H,
      ST_EXEC,
      ST_HALT
   } state_t;

   localparam logic [5:0] OP_BRA  = 6'h00;
   localparam logic [5:0] OP_BEQ  = 6'h01;
   localparam logic [5:0] OP_BNE  = 6'h02;
   localparam logic [5:0] OP_MOVL = 6'h03;
   localparam logic [5:0] OP_LDAR = 6'h04;
   localparam logic [5:0] OP_LD   = 6'h05;
   localparam logic [5:0] OP_ST   = 6'h06;
   localparam logic [5:0] OP_INC  = 6'h07;
   localparam logic [5:0] OP_DEC  = 6'h08;
   localparam logic [5:0] OP_ADD  = 6'h09;
   localparam logic [5:0] OP_SUB  = 6'h0A;
   localparam logic [5:0] OP_AND  = 6'h0B;
   localparam logic [5:0] OP_ORR  = 6'h0C;
   localparam logic [5:0] OP_XOR  = 6'h0D;
   localparam logic [5:0] OP_PSH  = 6'h0E;
   localparam logic [5:0] OP_POP  = 6'h0F;
   localparam logic [5:0] OP_HLT  = 6'h3F;

   localparam logic [2:0] FUN_DEC  = 3'b000;
   localparam logic [2:0] FUN_INC  = 3'b001;
   localparam logic [2:0] FUN_LOAD = 3'b010;
   localparam logic [2:0] FUN_CLR  = 3'b011;

   localparam logic [4:0] ALU_PASS_A = 5'b10000;
   localparam logic [4:0] ALU_ADD    = 5'b10100;
   localparam logic [4:0] ALU_SUB    = 5'b10110;
   localparam logic [4:0] ALU_AND    = 5'b10111;
   localparam logic [4:0] ALU_OR     = 5'b11000;
   localparam logic [4:0] ALU_XOR    = 5'b11001;

   localparam logic [2:0] ARF_SEL_PC   = 3'b011;
   localparam logic [2:0] ARF_SEL_AR   = 3'b101;
   localparam logic [2:0] ARF_SEL_SP   = 3'b110;
   localparam logic [2:0] ARF_SEL_ALL  = 3'b000;
   localparam logic [2:0] ARF_SEL_NONE = 3'b111;
   localparam logic [3:0] RF_SEL_ALL   = 4'b0000;
   localparam logic [3:0] RF_SEL_NONE  = 4'b1111;

   localparam logic [1:0] OUT_PC = 2'b00;
   localparam logic [1:0] OUT_AR = 2'b10;
   localparam logic [1:0] OUT_SP = 2'b11;

   localparam logic [1:0] MUX_ALU = 2'b00;
   localparam logic [1:0] MUX_MEM = 2'b10;
   localparam logic [1:0] MUX_IMM = 2'b11;

   typedef struct packed {
      logic [2:0] rf_out_a_sel;
      logic [2:0] rf_out_b_sel;
      logic [2:0] rf_fun_sel;
      logic [3:0] rf_reg_sel;
      logic [3:0] rf_scr_sel;
      logic [2:0] arf_fun_sel;
      logic [2:0] arf_reg_sel;
      logic [1:0] arf_out_c_sel;
      logic [1:0] arf_out_d_sel;
      logic [4:0] alu_fun_sel;
      logic       alu_wf;
      logic       ir_lh;
      logic       ir_write;
      logic       mem_cs;
      logic       mem_wr;
      logic [1:0] mux_a_sel;
      logic [1:0] mux_b_sel;
      logic       mux_c_sel;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '{
      rf_out_a_sel: 3'b000, rf_out_b_sel: 3'b000, rf_fun_sel: 3'b000,
      rf_reg_sel: RF_SEL_NONE, rf_scr_sel: 4'b1111, arf_fun_sel: 3'b000,
      arf_reg_sel: ARF_SEL_NONE, arf_out_c_sel: 2'b00, arf_out_d_sel: 2'b00,
      alu_fun_sel: 5'b00000, alu_wf: 1'b0, ir_lh: 1'b0, ir_write: 1'b0,
      mem_cs: 1'b1, mem_wr: 1'b0, mux_a_sel: 2'b00, mux_b_sel: 2'b00,
      mux_c_sel: 1'b0
   };

   // Active-low register enable: R1 sits in bit 3, R4 in bit 0.
   function automatic logic [3:0] rf_sel_n(input logic [1:0] r);
      return ~(4'b1000 >> r);
   endfunction

   function automatic logic [4:0] alu_code(input logic [5:0] op);
      case (op)
         OP_ADD:  return ALU_ADD;
         OP_SUB:  return ALU_SUB;
         OP_AND:  return ALU_AND;
         OP_ORR:  return ALU_OR;
         default: return ALU_XOR;
      endcase
   endfunction

endpackage

// File: rtl/decode_exec.sv
// Combinational EXEC-phase decoder: opcode, sequence count, IR fields and
// the Z flag produce the datapath control vector plus last-cycle/halt flags.
module decode_exec
   import cpu_ctrl_pkg::*;
#(
   parameter bit HALT_ON_UNDEF = 1'b1
) (
   input  logic [5:0] op,
   input  logic       s,
   input  logic [1:0] rx,
   input  logic [1:0] dst,
   input  logic [1:0] src1,
   input  logic [1:0] src2,
   input  logic [2:0] t,
   input  logic       flag_z,
   output ctrl_t      ctrl,
   output logic       last,
   output logic       halt
);

   logic first;
   logic take_branch;

   assign first       = (t == 3'd0);
   assign take_branch = (op == OP_BRA) || ((op == OP_BEQ) && flag_z) ||
                        ((op == OP_BNE) && !flag_z);

   always_comb begin
      ctrl = CTRL_IDLE;
      last = 1'b1;
      halt = 1'b0;
      case (op)
         OP_BRA, OP_BEQ, OP_BNE: begin
            if (take_branch) begin
               ctrl.mux_b_sel   = MUX_IMM;
               ctrl.arf_reg_sel = ARF_SEL_PC;
               ctrl.arf_fun_sel = FUN_LOAD;
            end
         end
         OP_MOVL: begin
            ctrl.mux_a_sel  = MUX_IMM;
            ctrl.rf_fun_sel = FUN_LOAD;
            ctrl.rf_reg_sel = rf_sel_n(rx);
         end
         OP_LDAR: begin
            ctrl.mux_b_sel   = MUX_IMM;
            ctrl.arf_reg_sel = ARF_SEL_AR;
            ctrl.arf_fun_sel = FUN_LOAD;
         end
         OP_LD: begin
            ctrl.arf_out_d_sel = OUT_AR;
            ctrl.mem_cs        = 1'b0;
            ctrl.mux_a_sel     = MUX_MEM;
            ctrl.rf_fun_sel    = FUN_LOAD;
            ctrl.rf_reg_sel    = rf_sel_n(rx);
         end
         OP_ST: begin
            ctrl.rf_out_a_sel  = {1'b0, rx};
            ctrl.alu_fun_sel   = ALU_PASS_A;
            ctrl.mux_c_sel     = 1'b0;
            ctrl.arf_out_d_sel = OUT_AR;
            ctrl.mem_cs        = 1'b0;
            ctrl.mem_wr        = 1'b1;
         end
         OP_INC, OP_DEC: begin
            ctrl.rf_fun_sel = (op == OP_INC) ? FUN_INC : FUN_DEC;
            ctrl.rf_reg_sel = rf_sel_n(rx);
         end
         OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_XOR: begin
            ctrl.rf_out_a_sel = {1'b0, src1};
            ctrl.rf_out_b_sel = {1'b0, src2};
            ctrl.alu_fun_sel  = alu_code(op);
            ctrl.alu_wf       = s;
            ctrl.mux_a_sel    = MUX_ALU;
            ctrl.rf_fun_sel   = FUN_LOAD;
            ctrl.rf_reg_sel   = rf_sel_n(dst);
         end
         OP_PSH: begin
            // Pre-decrement SP, then store through the ALU low byte.
            if (first) begin
               ctrl.arf_reg_sel = ARF_SEL_SP;
               ctrl.arf_fun_sel = FUN_DEC;
               last             = 1'b0;
            end else begin
               ctrl.rf_out_a_sel  = {1'b0, rx};
               ctrl.alu_fun_sel   = ALU_PASS_A;
               ctrl.mux_c_sel     = 1'b0;
               ctrl.arf_out_d_sel = OUT_SP;
               ctrl.mem_cs        = 1'b0;
               ctrl.mem_wr        = 1'b1;
            end
         end
         OP_POP: begin
            if (first) begin
               ctrl.arf_out_d_sel = OUT_SP;
               ctrl.mem_cs        = 1'b0;
               ctrl.mux_a_sel     = MUX_MEM;
               ctrl.rf_fun_sel    = FUN_LOAD;
               ctrl.rf_reg_sel    = rf_sel_n(rx);
               last               = 1'b0;
            end else begin
               ctrl.arf_reg_sel = ARF_SEL_SP;
               ctrl.arf_fun_sel = FUN_INC;
            end
         end
         OP_HLT:  halt = 1'b1;
         default: halt = HALT_ON_UNDEF;
      endcase
   end

endmodule

// File: rtl/cpu_control_unit.sv
// Hardwired CPU sequencer: INIT, two-byte fetch, 1-2 cycle EXEC, HALT.
// Control outputs are decoded from state/T/IR and forced idle during reset.
module cpu_control_unit
   import cpu_ctrl_pkg::*;
#(
   parameter bit HALT_ON_UNDEF = 1'b1
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [15:0] IROut,
   input  logic [3:0]  Flags,
   output logic [2:0]  RF_OutASel,
   output logic [2:0]  RF_OutBSel,
   output logic [2:0]  RF_FunSel,
   output logic [3:0]  RF_RegSel,
   output logic [3:0]  RF_ScrSel,
   output logic [2:0]  ARF_FunSel,
   output logic [2:0]  ARF_RegSel,
   output logic [1:0]  ARF_OutCSel,
   output logic [1:0]  ARF_OutDSel,
   output logic [4:0]  ALU_FunSel,
   output logic        ALU_WF,
   output logic        IR_LH,
   output logic        IR_Write,
   output logic        Mem_CS,
   output logic        Mem_WR,
   output logic [1:0]  MuxASel,
   output logic [1:0]  MuxBSel,
   output logic        MuxCSel,
   output logic        Halted
);

   state_t     state;
   logic [2:0] seq_t;
   logic       halted_q;
   ctrl_t      exec_ctrl;
   ctrl_t      ctrl;
   logic       exec_last;
   logic       exec_halt;
   logic       unused_bits;

   // IR[1:0] and the C/N/O flags never influence sequencing.
   assign unused_bits = ^{IROut[1:0], Flags[2:0]};

   decode_exec #(.HALT_ON_UNDEF(HALT_ON_UNDEF)) u_decode_exec (
      .op     (IROut[15:10]),
      .s      (IROut[9]),
      .rx     (IROut[9:8]),
      .dst    (IROut[7:6]),
      .src1   (IROut[5:4]),
      .src2   (IROut[3:2]),
      .t      (seq_t),
      .flag_z (Flags[3]),
      .ctrl   (exec_ctrl),
      .last   (exec_last),
      .halt   (exec_halt)
   );

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state    <= ST_INIT;
         seq_t    <= 3'd0;
         halted_q <= 1'b0;
      end else begin
         case (state)
            ST_INIT:    state <= ST_FETCH_L;
            ST_FETCH_L: state <= ST_FETCH_H;
            ST_FETCH_H: begin
               state <= ST_EXEC;
               seq_t <= 3'd0;
            end
            ST_EXEC: begin
               if (exec_halt) begin
                  state    <= ST_HALT;
                  halted_q <= 1'b1;
               end else if (exec_last) begin
                  state <= ST_FETCH_L;
                  seq_t <= 3'd0;
               end else begin
                  seq_t <= seq_t + 3'd1;
               end
            end
            ST_HALT: state <= ST_HALT;
            default: state <= ST_INIT;
         endcase
      end
   end

   // Reset gates the decode so INIT's clears only fire once Reset is released.
   always_comb begin
      ctrl = CTRL_IDLE;
      if (Reset) begin
         case (state)
            ST_INIT: begin
               ctrl.arf_fun_sel = FUN_CLR;
               ctrl.arf_reg_sel = ARF_SEL_ALL;
               ctrl.rf_fun_sel  = FUN_CLR;
               ctrl.rf_reg_sel  = RF_SEL_ALL;
            end
            ST_FETCH_L, ST_FETCH_H: begin
               ctrl.arf_out_d_sel = OUT_PC;
               ctrl.mem_cs        = 1'b0;
               ctrl.ir_write      = 1'b1;
               ctrl.ir_lh         = (state == ST_FETCH_H);
               ctrl.arf_reg_sel   = ARF_SEL_PC;
               ctrl.arf_fun_sel   = FUN_INC;
            end
            ST_EXEC: ctrl = exec_ctrl;
            default: ctrl = CTRL_IDLE;
         endcase
      end
   end

   assign RF_OutASel  = ctrl.rf_out_a_sel;
   assign RF_OutBSel  = ctrl.rf_out_b_sel;
   assign RF_FunSel   = ctrl.rf_fun_sel;
   assign RF_RegSel   = ctrl.rf_reg_sel;
   assign RF_ScrSel   = ctrl.rf_scr_sel;
   assign ARF_FunSel  = ctrl.arf_fun_sel;
   assign ARF_RegSel  = ctrl.arf_reg_sel;
   assign ARF_OutCSel = ctrl.arf_out_c_sel;
   assign ARF_OutDSel = ctrl.arf_out_d_sel;
   assign ALU_FunSel  = ctrl.alu_fun_sel;
   assign ALU_WF      = ctrl.alu_wf;
   assign IR_LH       = ctrl.ir_lh;
   assign IR_Write    = ctrl.ir_write;
   assign Mem_CS      = ctrl.mem_cs;
   assign Mem_WR      = ctrl.mem_wr;
   assign MuxASel     = ctrl.mux_a_sel;
   assign MuxBSel     = ctrl.mux_b_sel;
   assign MuxCSel     = ctrl.mux_c_sel;
   assign Halted      = halted_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench: the sequencer drives a behavioural datapath model (RF, ARF,
// IR, ALU, byte memory); register and memory effects are checked per step.
`timescale 1ns/1ps
module tb_cpu_control_unit;

   logic clk, rst_n, rst2_n;
   logic [15:0] ir2;
   logic [3:0]  flags2;

   logic [2:0] RF_OutASel, RF_OutBSel, RF_FunSel, ARF_FunSel, ARF_RegSel;
   logic [3:0] RF_RegSel, RF_ScrSel;
   logic [1:0] ARF_OutCSel, ARF_OutDSel, MuxASel, MuxBSel;
   logic [4:0] ALU_FunSel;
   logic       ALU_WF, IR_LH, IR_Write, Mem_CS, Mem_WR, MuxCSel, Halted;

   logic [2:0] a_sel2, b_sel2, rf_fun2, arf_fun2, arf_reg2;
   logic [3:0] rf_reg2, scr2;
   logic [1:0] out_c2, out_d2, mux_a2, mux_b2;
   logic [4:0] alu_fun2;
   logic       wf2, lh2, irw2, cs2, wr2, mux_c2, halted2;

   // behavioural datapath state
   logic [15:0] rf [4];
   logic [15:0] pc, ar, sp, ir;
   logic [3:0]  flags;
   logic [7:0]  mem [65536];

   logic [15:0] out_a, out_b, out_c, addr, alu_out, mux_a, mux_b;
   logic [7:0]  mem_out, mux_c;
   logic [3:0]  alu_flags;
   logic [16:0] sum;

   int total = 0;
   int bad   = 0;

   logic [41:0] outs, outs2;
   assign outs  = {RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel, ARF_FunSel,
                   ARF_RegSel, ARF_OutCSel, ARF_OutDSel, ALU_FunSel, ALU_WF, IR_LH,
                   IR_Write, Mem_CS, Mem_WR, MuxASel, MuxBSel, MuxCSel};
   assign outs2 = {a_sel2, b_sel2, rf_fun2, rf_reg2, scr2, arf_fun2, arf_reg2, out_c2,
                   out_d2, alu_fun2, wf2, lh2, irw2, cs2, wr2, mux_a2, mux_b2, mux_c2};

   localparam logic [41:0] IDLE   = {3'b0, 3'b0, 3'b000, 4'hF, 4'hF, 3'b000, 3'b111, 2'b0,
                                     2'b0, 5'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b0, 2'b0, 1'b0};
   localparam logic [41:0] INIT_V = {3'b0, 3'b0, 3'b011, 4'h0, 4'hF, 3'b011, 3'b000, 2'b0,
                                     2'b0, 5'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b0, 2'b0, 1'b0};
   localparam logic [41:0] FL_V   = {3'b0, 3'b0, 3'b000, 4'hF, 4'hF, 3'b001, 3'b011, 2'b0,
                                     2'b0, 5'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b0, 2'b0, 1'b0};
   localparam logic [41:0] FH_V   = {3'b0, 3'b0, 3'b000, 4'hF, 4'hF, 3'b001, 3'b011, 2'b0,
                                     2'b0, 5'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b0, 2'b0, 1'b0};

   cpu_control_unit #(.HALT_ON_UNDEF(1'b1)) dut (
      .Clock(clk), .Reset(rst_n), .IROut(ir), .Flags(flags),
      .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
      .RF_RegSel(RF_RegSel), .RF_ScrSel(RF_ScrSel), .ARF_FunSel(ARF_FunSel),
      .ARF_RegSel(ARF_RegSel), .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel),
      .ALU_FunSel(ALU_FunSel), .ALU_WF(ALU_WF), .IR_LH(IR_LH), .IR_Write(IR_Write),
      .Mem_CS(Mem_CS), .Mem_WR(Mem_WR), .MuxASel(MuxASel), .MuxBSel(MuxBSel),
      .MuxCSel(MuxCSel), .Halted(Halted)
   );

   cpu_control_unit #(.HALT_ON_UNDEF(1'b0)) dut_nop (
      .Clock(clk), .Reset(rst2_n), .IROut(ir2), .Flags(flags2),
      .RF_OutASel(a_sel2), .RF_OutBSel(b_sel2), .RF_FunSel(rf_fun2),
      .RF_RegSel(rf_reg2), .RF_ScrSel(scr2), .ARF_FunSel(arf_fun2),
      .ARF_RegSel(arf_reg2), .ARF_OutCSel(out_c2), .ARF_OutDSel(out_d2),
      .ALU_FunSel(alu_fun2), .ALU_WF(wf2), .IR_LH(lh2), .IR_Write(irw2),
      .Mem_CS(cs2), .Mem_WR(wr2), .MuxASel(mux_a2), .MuxBSel(mux_b2),
      .MuxCSel(mux_c2), .Halted(halted2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] reg_upd(input logic [15:0] cur, input logic [2:0] fs,
                                           input logic [15:0] d);
      case (fs)
         3'b000:  return cur - 16'd1;
         3'b001:  return cur + 16'd1;
         3'b010:  return d;
         3'b011:  return 16'h0000;
         default: return cur;
      endcase
   endfunction

   always_comb begin
      out_a = rf[RF_OutASel[1:0]];
      out_b = rf[RF_OutBSel[1:0]];
      case (ARF_OutCSel)
         2'b10:   out_c = ar;
         2'b11:   out_c = sp;
         default: out_c = pc;
      endcase
      case (ARF_OutDSel)
         2'b10:   addr = ar;
         2'b11:   addr = sp;
         default: addr = pc;
      endcase
      mem_out   = mem[addr];
      sum       = 17'h0;
      alu_out   = 16'h0;
      alu_flags = flags;
      case (ALU_FunSel)
         5'b10000: alu_out = out_a;
         5'b10100: begin
            sum = {1'b0, out_a} + {1'b0, out_b};
            alu_out = sum[15:0];
            alu_flags[2] = sum[16];
            alu_flags[0] = (out_a[15] == out_b[15]) && (alu_out[15] != out_a[15]);
         end
         5'b10110: begin
            sum = {1'b0, out_a} + {1'b0, ~out_b} + 17'd1;
            alu_out = sum[15:0];
            alu_flags[2] = sum[16];
            alu_flags[0] = (out_a[15] != out_b[15]) && (alu_out[15] != out_a[15]);
         end
         5'b10111: alu_out = out_a & out_b;
         5'b11000: alu_out = out_a | out_b;
         5'b11001: alu_out = out_a ^ out_b;
         default:  alu_out = 16'h0;
      endcase
      alu_flags[3] = (alu_out == 16'h0);
      alu_flags[1] = alu_out[15];
      case (MuxASel)
         2'b00:   mux_a = alu_out;
         2'b01:   mux_a = out_c;
         2'b10:   mux_a = {{8{mem_out[7]}}, mem_out};
         default: mux_a = {{8{ir[7]}}, ir[7:0]};
      endcase
      case (MuxBSel)
         2'b00:   mux_b = alu_out;
         2'b01:   mux_b = out_c;
         2'b10:   mux_b = {{8{mem_out[7]}}, mem_out};
         default: mux_b = {{8{ir[7]}}, ir[7:0]};
      endcase
      mux_c = MuxCSel ? alu_out[15:8] : alu_out[7:0];
   end

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (!RF_RegSel[3-i]) rf[i] <= reg_upd(rf[i], RF_FunSel, mux_a);
      if (!ARF_RegSel[2]) pc <= reg_upd(pc, ARF_FunSel, mux_b);
      if (!ARF_RegSel[1]) ar <= reg_upd(ar, ARF_FunSel, mux_b);
      if (!ARF_RegSel[0]) sp <= reg_upd(sp, ARF_FunSel, mux_b);
      if (!Mem_CS && Mem_WR) mem[addr] <= mux_c;
      if (IR_Write) begin
         if (IR_LH) ir[15:8] <= mem_out;
         else       ir[7:0]  <= mem_out;
      end
      if (ALU_WF) flags <= alu_flags;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input int n);
      repeat (n) tick();
   endtask

   task automatic load_word(input logic [15:0] a, input logic [15:0] w);
      mem[a]         <= w[7:0];
      mem[a + 16'd1] <= w[15:8];
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n  = 1'b0;
      rst2_n = 1'b0;
      ir2    = 16'h8000;
      flags2 = 4'h0;
      load_word(16'h0000, 16'h0C03);  // MOVL R1,0x03
      load_word(16'h0002, 16'h0C05);  // MOVL R1,0x05
      load_word(16'h0004, 16'h0DFE);  // MOVL R2,0xFE
      load_word(16'h0006, 16'h2684);  // ADD S R3=R1+R2
      load_word(16'h0008, 16'h2A00);  // SUB S R1=R1-R1
      load_word(16'h000A, 16'h0840);  // BNE 0x40
      load_word(16'h000C, 16'h0440);  // BEQ 0x40
      load_word(16'h0040, 16'h0080);  // BRA 0x80
      load_word(16'hFF80, 16'h0FAB);  // MOVL R4,0xAB
      load_word(16'hFF82, 16'h3B00);  // PSH R4
      load_word(16'hFF84, 16'h3C00);  // POP R1
      load_word(16'hFF86, 16'h1010);  // LDAR 0x10
      load_word(16'hFF88, 16'h1800);  // ST R1
      load_word(16'hFF8A, 16'h1C00);  // INC R1
      load_word(16'hFF8C, 16'h1500);  // LD R2
      load_word(16'hFF8E, 16'hFC00);  // HLT
      pc <= 16'h1234; ar <= 16'h4321; sp <= 16'h5555; ir <= 16'h0000; flags <= 4'h0;
      for (int i = 0; i < 4; i++) rf[i] <= 16'h7777;

      repeat (2) @(posedge clk);
      #1;
      chk("reset_idle", outs, IDLE);
      chk("reset_halted", Halted, 1'b0);

      @(negedge clk); rst_n = 1'b1; #1;
      chk("init_vec", outs, INIT_V);
      tick();
      chk("init_pc", pc, 16'h0000);
      chk("init_sp", sp, 16'h0000);
      chk("init_r4", rf[3], 16'h0000);
      chk("fetch_l_vec", outs, FL_V);
      tick();
      chk("ir_low", ir[7:0], 8'h03);
      chk("pc_after_fl", pc, 16'h0001);
      chk("fetch_h_vec", outs, FH_V);
      tick();
      chk("ir_full", ir, 16'h0C03);
      chk("pc_after_fh", pc, 16'h0002);
      chk("movl_ctrl", {MuxASel, RF_FunSel, RF_RegSel}, {2'b11, 3'b010, 4'b0111});
      tick();
      chk("movl_r1", rf[0], 16'h0003);

      step(6);
      chk("movl_r1_5", rf[0], 16'h0005);
      chk("movl_r2_sext", rf[1], 16'hFFFE);
      tick();
      chk("add_fetch_wf", ALU_WF, 1'b0);
      tick();
      chk("add_exec_ctrl", {ALU_WF, ALU_FunSel, RF_RegSel, RF_OutASel, RF_OutBSel, MuxASel},
          {1'b1, 5'b10100, 4'b1101, 3'd0, 3'd1, 2'b00});
      tick();
      chk("add_r3", rf[2], 16'h0003);
      chk("add_carry", flags[2], 1'b1);
      chk("add_next_pc", {pc, ARF_OutDSel, ALU_WF}, {16'h0008, 2'b00, 1'b0});

      step(3);
      chk("sub_r1", rf[0], 16'h0000);
      chk("sub_z", flags[3], 1'b1);
      step(2);
      chk("bne_no_write", ARF_RegSel, 3'b111);
      tick();
      chk("bne_pc", pc, 16'h000C);
      step(3);
      chk("beq_pc", pc, 16'h0040);
      step(3);
      chk("bra_pc_sext", pc, 16'hFF80);
      step(3);
      chk("movl_r4", rf[3], 16'hFFAB);

      step(2);
      chk("psh_t0", {ARF_RegSel, ARF_FunSel}, {3'b110, 3'b000});
      tick();
      chk("psh_sp", sp, 16'hFFFF);
      chk("psh_t1", {Mem_CS, Mem_WR, ARF_OutDSel, ALU_FunSel, RF_OutASel},
          {1'b0, 1'b1, 2'b11, 5'b10000, 3'd3});
      tick();
      chk("psh_mem", mem[16'hFFFF], 8'hAB);
      chk("psh_4cyc", outs, FL_V);
      chk("psh_pc", pc, 16'hFF84);

      step(4);
      chk("pop_r1", rf[0], 16'hFFAB);
      chk("pop_sp", sp, 16'h0000);
      step(3);
      chk("ldar_ar", ar, 16'h0010);
      step(3);
      chk("st_mem", mem[16'h0010], 8'hAB);
      step(3);
      chk("inc_r1", rf[0], 16'hFFAC);
      step(3);
      chk("ld_r2", rf[1], 16'hFFAB);

      step(3);
      chk("hlt_halted", Halted, 1'b1);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("halt_hold", {Halted, outs}, {1'b1, IDLE});
      end
      chk("halt_pc", pc, 16'hFF90);

      @(negedge clk); rst_n = 1'b0; #1;
      chk("reset_leaves_halt", {Halted, outs}, {1'b0, IDLE});
      load_word(16'h0000, 16'h8000);  // opcode 0x20
      @(negedge clk); rst_n = 1'b1; rst2_n = 1'b1;
      step(3);
      chk("undef_exec_idle", outs, IDLE);
      chk("undef_nop_exec_idle", outs2, IDLE);
      tick();
      chk("undef_halt_vs_nop", {Halted, halted2, cs2, irw2}, 4'b1001);

      @(negedge clk); rst_n = 1'b0;
      load_word(16'h0000, 16'h3800);  // PSH R1
      mem[16'hFFFF] <= 8'h5A;
      @(negedge clk); rst_n = 1'b1;
      step(4);
      chk("abort_pre_t1", {Mem_CS, Mem_WR}, 2'b01);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_cs", Mem_CS, 1'b1);
      chk("abort_idle", outs, IDLE);
      @(posedge clk); #1;
      chk("abort_mem", mem[16'hFFFF], 8'h5A);
      @(negedge clk); rst_n = 1'b1; #1;
      chk("abort_init", outs, INIT_V);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
